// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling from a free
// cycle counter, single-cycle done / frame_err pulses.
`timescale 1ns/1ps
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  localparam logic [15:0] BIT_TC  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_TC = 16'(HALF_BIT - 1);

  logic        r_rx_meta;
  logic        r_rx_s;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_dout;
  logic        r_done;
  logic        r_ferr;
  logic        r_busy;
  logic        w_bit_tc;
  logic        w_half_tc;

  assign w_bit_tc  = (r_cnt == BIT_TC);
  assign w_half_tc = (r_cnt == HALF_TC);

  assign dout      = r_dout;
  assign done      = r_done;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

  // Line synchroniser; resets to the idle (high) level so reset cannot fake a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receive FSM with bit timing counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_dout  <= 8'h00;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= 16'd0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_START: begin
          if (w_half_tc) begin
            r_cnt <= 16'd0;
            if (!r_rx_s) begin
              r_idx   <= 3'd0;
              r_state <= S_DATA;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_tc) begin
            r_cnt          <= 16'd0;
            r_shift[r_idx] <= r_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_tc) begin
            r_cnt  <= 16'd0;
            r_busy <= 1'b0;
            if (r_rx_s) begin
              r_dout  <= r_shift;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_RECOVER;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RECOVER: begin
          // A held-low line (break) must go high before a new start is accepted
          r_busy <= 1'b0;
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RECOVER;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed + randomized bench for uart_rx_sampler; expected bytes, error counts
// and timing come from a frame-level model of the serial protocol.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  localparam int CPB    = 16;
  localparam int HALF   = 8;
  localparam int CLK_NS = 10;
  // Pin edge driven mid-cycle: half cycle to first flop, two sync stages,
  // then HALF + 9 bit periods to the stop sample, seen half a cycle later.
  localparam int LAT_NS = CLK_NS / 2 + 2 * CLK_NS + (HALF + 9 * CPB) * CLK_NS + CLK_NS / 2;
  localparam int BUSY_FRAME = HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       done;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_dout = 8'h00;
  int  exp_fe = 0;
  int  fe_cnt = 0;
  int  both_cnt = 0;
  int  dbl_cnt = 0;
  int  busy_cyc = 0;
  logic prev_done = 1'b0;
  logic prev_fe = 1'b0;
  time t_start = 0;
  time t_done = 0;

  uart_rx_sampler #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .dout(dout), .done(done), .frame_err(frame_err), .busy(busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      got_q.push_back(dout);
      t_done = $time;
    end
    if (frame_err) fe_cnt++;
    if (done && frame_err) both_cnt++;
    if ((done && prev_done) || (frame_err && prev_fe)) dbl_cnt++;
    prev_done = done;
    prev_fe = frame_err;
    if (busy) busy_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller sits on a negedge; leaves rx high on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_cycles);
    rx = 1'b0;
    t_start = $time;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_v;
    repeat (stop_cycles) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic verify(input string tag);
    #1;
    check({tag, "_ndone"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_nferr"}, fe_cnt, exp_fe);
    check({tag, "_dout"}, dout, exp_dout);
    check({tag, "_overlap"}, both_cnt, 0);
    check({tag, "_pulsewidth"}, dbl_cnt, 0);
    @(negedge clk);
  endtask

  initial begin
    int b0;
    logic [7:0] rb;
    logic       rstop;
    int         gap;

    // Reset and quiet line
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(50);
    #1;
    check("reset_busy_cycles", busy_cyc, 0);
    check("reset_busy", busy, 1'b0);
    verify("reset");

    // Single frame: value, latency and busy window
    b0 = busy_cyc;
    send_byte(8'hA5, 1'b1, CPB);
    exp_q.push_back(8'hA5);
    exp_dout = 8'hA5;
    #1;
    check("a5_latency_ns", 32'(t_done - t_start), LAT_NS);
    check("a5_busy_cycles", busy_cyc - b0, BUSY_FRAME);
    check("a5_busy_after", busy, 1'b0);
    verify("a5");

    // Back-to-back frames with a single stop bit
    idle(5);
    send_byte(8'h00, 1'b1, CPB);
    send_byte(8'hFF, 1'b1, CPB);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_dout = 8'hFF;
    verify("b2b");

    // 50 ns glitch: busy only for the start half-bit, nothing reported
    b0 = busy_cyc;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    #1;
    check("glitch_busy_cycles", busy_cyc - b0, HALF);
    check("glitch_busy", busy, 1'b0);
    verify("glitch");

    // Framing error with line held low for three bit times
    b0 = busy_cyc;
    send_byte(8'h3C, 1'b0, 3 * CPB);
    exp_fe++;
    #1;
    check("ferr_busy_cycles", busy_cyc - b0, BUSY_FRAME);
    verify("ferr");
    idle(CPB);
    send_byte(8'h81, 1'b1, CPB);
    exp_q.push_back(8'h81);
    exp_dout = 8'h81;
    verify("after_ferr");

    // Reset halfway through bit 4 of 8'h5A
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h5A >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_dout = 8'h00;
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    idle(200);
    verify("aborted");
    send_byte(8'hC3, 1'b1, CPB);
    exp_q.push_back(8'hC3);
    exp_dout = 8'hC3;
    verify("c3");

    // Random frames, random gaps (0 = back-to-back), occasional bad stop bit
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      gap = rstop ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 30));
      send_byte(rb, rstop, CPB);
      if (rstop) begin
        exp_q.push_back(rb);
        exp_dout = rb;
      end else begin
        exp_fe++;
      end
      if (gap > 0) idle(gap);
      if ((n % 4) == 3) verify("rand");
    end
    idle(2 * CPB);
    verify("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
